// File: rtl/mem_pkg.sv
// Shared memory-system definitions: fill FSM encoding, block geometry and
// the default burst/latency figures used by memory_system and both caches.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int BLOCK_OFFSET_BITS = 4;  // 16-byte cache blocks
  localparam int WORD_BYTES        = 2;  // 16-bit memory words
  localparam int WORDS_PER_BLOCK   = 8;
  localparam int MEM_LATENCY       = 4;

  // Counter width for a count-to-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Count-to-N word counter with a terminal flag. Wraps to zero after N-1 and
// can be cleared synchronously when the fill it belongs to is not running.
module fill_word_counter #(
  parameter int N  = 8,
  parameter int CW = mem_pkg::cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache misses onto the single pipelined main memory,
// issues the block read burst and steers the returning words' write enables
// to the cache that owns the fill.
module mem_fill_arbiter
  import mem_pkg::*;
#(
  parameter int AWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = mem_pkg::MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [AWIDTH-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [AWIDTH-1:0] dcache_miss_addr,
  input  logic              mem_data_valid,
  output logic              mem_rd_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [AWIDTH-1:0] fill_addr,
  output logic              icache_data_wen,
  output logic              icache_tag_wen,
  output logic              dcache_data_wen,
  output logic              dcache_tag_wen,
  output logic              busy,
  output logic              grant_d
);

  localparam int CW = cnt_width(WORDS_PER_BLOCK);

  // Reject geometries the burst sequencing cannot express: the burst must
  // exactly cover one aligned block, and memory must have some latency.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      WORDS_PER_BLOCK * WORD_BYTES != (1 << BLOCK_OFFSET_BITS)) begin : g_bad_cfg
    $error("mem_fill_arbiter: unsupported block geometry or latency");
  end

  fill_state_e       state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  // One register serves as both the current grant and the last-grant
  // history used for round-robin: they only ever change together.
  logic              grant_d_q, grant_d_d;
  logic              issue_done_q, issue_done_d;

  logic [CW-1:0]     issue_cnt, rcv_cnt;
  logic              issue_last, rcv_last;
  logic              in_fill, issue_en, rcv_en;
  logic              any_miss, pick_d;
  logic [AWIDTH-1:0] miss_addr, issue_addr;

  assign in_fill    = (state_q == ST_FILL);
  assign issue_en   = in_fill && !issue_done_q;
  // Responses only count while a fill owns the memory; stray or post-reset
  // responses in IDLE/DONE are dropped here.
  assign rcv_en     = in_fill && mem_data_valid;
  assign issue_addr = base_q + AWIDTH'(issue_cnt) * AWIDTH'(WORD_BYTES);

  // Round-robin pick: a lone miss wins; with both pending, serve the side
  // that was not granted last (after reset that is the D-cache).
  always_comb begin
    any_miss  = icache_miss || dcache_miss;
    pick_d    = dcache_miss && (!icache_miss || !grant_d_q);
    miss_addr = pick_d ? dcache_miss_addr : icache_miss_addr;
  end

  // Fill FSM next state; grant and block base are captured only in IDLE so a
  // running fill cannot be preempted or retargeted.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    grant_d_d = grant_d_q;
    case (state_q)
      ST_IDLE: begin
        if (any_miss) begin
          state_d   = ST_FILL;
          base_d    = {miss_addr[AWIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
          grant_d_d = pick_d;
        end
      end
      ST_FILL: begin
        if (rcv_en && rcv_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue bookkeeping: stop after the last word and keep the last address
  // on the memory bus once the burst has been issued.
  always_comb begin
    issue_done_d = in_fill ? (issue_done_q || (issue_en && issue_last)) : 1'b0;
    mem_addr_d   = issue_en ? issue_addr : mem_addr_q;
  end

  // State, grant, base and issue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      mem_addr_q   <= '0;
      grant_d_q    <= 1'b0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      grant_d_q    <= grant_d_d;
      issue_done_q <= issue_done_d;
    end
  end

  fill_word_counter #(.N(WORDS_PER_BLOCK), .CW(CW)) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_fill),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .last (issue_last)
  );

  fill_word_counter #(.N(WORDS_PER_BLOCK), .CW(CW)) u_rcv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_fill),
    .en   (rcv_en),
    .cnt  (rcv_cnt),
    .last (rcv_last)
  );

  assign mem_rd_en       = issue_en;
  assign mem_addr        = issue_en ? issue_addr : mem_addr_q;
  assign fill_addr       = base_q + AWIDTH'(rcv_cnt) * AWIDTH'(WORD_BYTES);
  assign dcache_data_wen = rcv_en && grant_d_q;
  assign icache_data_wen = rcv_en && !grant_d_q;
  assign dcache_tag_wen  = rcv_en && rcv_last && grant_d_q;
  assign icache_tag_wen  = rcv_en && rcv_last && !grant_d_q;
  assign busy            = (state_q != ST_IDLE);
  assign grant_d         = grant_d_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
`timescale 1ns/1ps
module tb_mem_fill_arbiter;

  localparam int AW = 16;
  localparam int N  = 8;
  localparam int L  = 4;
  localparam int QD = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_miss, dcache_miss;
  logic [AW-1:0] icache_miss_addr, dcache_miss_addr;
  logic          mem_data_valid;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr, fill_addr;
  logic          icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen;
  logic          busy, grant_d;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.AWIDTH(AW), .WORDS_PER_BLOCK(N), .MEM_LATENCY(L)) dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .fill_addr        (fill_addr),
    .icache_data_wen  (icache_data_wen),
    .icache_tag_wen   (icache_tag_wen),
    .dcache_data_wen  (dcache_data_wen),
    .dcache_tag_wen   (dcache_tag_wen),
    .busy             (busy),
    .grant_d          (grant_d)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a fill is described only by its start cycle, base and
  // owner; every output is a function of the offset into that fill.
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [15:0] m_base = '0;
  logic [15:0] m_hold = '0;
  logic        m_gd = 1'b0;
  logic        m_last_d = 1'b0;
  int          m_grants = 0;

  // Memory model: fixed-latency echo of mem_rd_en, plus injected stray pulses.
  bit          vq[QD];
  bit          inject_v = 1'b0;

  logic [15:0] snap_addr = '0;
  logic        snap_gd = 1'b0;
  int          snap_cnt = 0;
  logic        dut_seq[8];
  int          tag_cnt = 0;
  int          wen_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_idle(input int c);
    return !m_active || (c > m_start + N + L);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_base   = '0;
    m_hold   = '0;
    m_gd     = 1'b0;
    m_last_d = 1'b0;
  endtask

  // One clock cycle: present memory response, check outputs at negedge,
  // advance the model at posedge, return just after the edge.
  task automatic tick();
    bit          fill;
    int          off;
    logic        e_rd, e_wen, e_tag;
    logic [15:0] e_addr;
    bit          pick_d;
    if (rst) model_reset();
    mem_data_valid = vq[cyc % QD] | inject_v;
    vq[cyc % QD] = 1'b0;
    inject_v = 1'b0;
    @(negedge clk);
    fill   = !m_idle(cyc);
    off    = cyc - m_start;
    e_rd   = fill && off < N;
    e_addr = e_rd ? m_base + 16'(2 * off) : m_hold;
    e_wen  = fill && off >= L && off < N + L;
    e_tag  = fill && off == N - 1 + L;
    chk("busy", busy, fill);
    chk("grant_d", grant_d, m_gd);
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("mem_addr", mem_addr, e_addr);
    chk("dcache_data_wen", dcache_data_wen, e_wen && m_gd);
    chk("icache_data_wen", icache_data_wen, e_wen && !m_gd);
    chk("dcache_tag_wen", dcache_tag_wen, e_tag && m_gd);
    chk("icache_tag_wen", icache_tag_wen, e_tag && !m_gd);
    if (e_wen) chk("fill_addr", fill_addr, m_base + 16'(2 * (off - L)));
    if (icache_tag_wen || dcache_tag_wen) tag_cnt++;
    if (icache_data_wen || dcache_data_wen) wen_cnt++;
    if (fill && off == 0) begin
      snap_addr = mem_addr;
      snap_gd   = grant_d;
      dut_seq[snap_cnt % 8] = grant_d;
      snap_cnt++;
    end
    if (mem_rd_en === 1'b1) vq[(cyc + L) % QD] = 1'b1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (fill && off == N - 1) m_hold = m_base + 16'(2 * (N - 1));
      if (m_idle(cyc) && (icache_miss || dcache_miss)) begin
        pick_d   = dcache_miss && (!icache_miss || !m_last_d);
        m_base   = (pick_d ? dcache_miss_addr : icache_miss_addr) & 16'hFFF0;
        m_gd     = pick_d;
        m_last_d = pick_d;
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_grants++;
        $display("grant cycle=%0d side=%s base=%h", cyc, pick_d ? "D" : "I", m_base);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int k = 0;
    while (m_grants < target && k < budget) begin
      tick();
      k++;
    end
    chk("grant_wait", 16'(m_grants), 16'(target));
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (!m_idle(cyc) && k < budget) begin
      tick();
      k++;
    end
    chk("idle_wait", 16'(m_idle(cyc)), 16'd1);
    tick();
    tick();
  endtask

  typedef struct {
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    logic        exp_gd;
    logic [15:0] exp_base;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vt[3];

  initial begin
    int g0;
    int quiet;
    for (int i = 0; i < QD; i++) vq[i] = 1'b0;
    rst = 1'b1;
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    icache_miss_addr = '0;
    dcache_miss_addr = '0;
    mem_data_valid = 1'b0;

    vt[0] = '{1'b0, 16'h0000, 1'b1, 16'h1236, 1'b1, 16'h1230, 16'h123E};
    vt[1] = '{1'b1, 16'h00F0, 1'b0, 16'h0000, 1'b0, 16'h00F0, 16'h00FE};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 16'hFFF0, 16'hFFFE};

    do_reset();
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_grant_d", grant_d, 1'b0);

    // Single-miss fills from the vector table.
    for (int v = 0; v < 3; v++) begin
      tag_cnt = 0;
      wen_cnt = 0;
      g0 = m_grants;
      icache_miss = vt[v].im;
      icache_miss_addr = vt[v].ia;
      dcache_miss = vt[v].dm;
      dcache_miss_addr = vt[v].da;
      wait_grants(g0 + 1, 20);
      icache_miss = 1'b0;
      dcache_miss = 1'b0;
      run_until_idle(40);
      chk("vec_grant_d", snap_gd, vt[v].exp_gd);
      chk("vec_first_addr", snap_addr, vt[v].exp_base);
      chk("vec_last_addr", mem_addr, vt[v].exp_last);
      chk("vec_tag_pulses", 16'(tag_cnt), 16'd1);
      chk("vec_wen_pulses", 16'(wen_cnt), 16'(N));
    end

    // Simultaneous misses right after reset: D first, then I.
    do_reset();
    snap_cnt = 0;
    icache_miss = 1'b1; icache_miss_addr = 16'h3450;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h5678;
    g0 = m_grants;
    wait_grants(g0 + 1, 20);
    dcache_miss = 1'b0;
    wait_grants(g0 + 2, 40);
    icache_miss = 1'b0;
    run_until_idle(40);
    chk("simul_first_d", dut_seq[0], 1'b1);
    chk("simul_second_i", dut_seq[1], 1'b0);
    chk("simul_i_base", snap_addr, 16'h3450);

    // Both misses held across three fills: D, I, D.
    do_reset();
    snap_cnt = 0;
    icache_miss = 1'b1; icache_miss_addr = 16'h0A0A;
    dcache_miss = 1'b1; dcache_miss_addr = 16'hB0B4;
    g0 = m_grants;
    wait_grants(g0 + 3, 100);
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    run_until_idle(40);
    chk("alt_0_d", dut_seq[0], 1'b1);
    chk("alt_1_i", dut_seq[1], 1'b0);
    chk("alt_2_d", dut_seq[2], 1'b1);

    // Reset at cycle 6 of a D fill; in-flight responses must be ignored.
    do_reset();
    dcache_miss = 1'b1; dcache_miss_addr = 16'h4448;
    tick();
    dcache_miss = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_en", mem_rd_en, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    wen_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      inject_v = (k % 2 == 0);
      tick();
    end
    chk("late_valid_wen", 16'(wen_cnt), 16'd0);
    tag_cnt = 0;
    icache_miss = 1'b1; icache_miss_addr = 16'h2220;
    g0 = m_grants;
    wait_grants(g0 + 1, 20);
    icache_miss = 1'b0;
    run_until_idle(40);
    chk("post_rst_grant_d", snap_gd, 1'b0);
    chk("post_rst_base", snap_addr, 16'h2220);
    chk("post_rst_tag", 16'(tag_cnt), 16'd1);

    // Randomized traffic against the model.
    do_reset();
    quiet = 0;
    for (int k = 0; k < 800; k++) begin
      if (quiet > 0) begin
        quiet--;
        rst = 1'b0;
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
        quiet = L + 2;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 3) == 0) icache_miss = ~icache_miss;
        if ($urandom_range(0, 3) == 0) dcache_miss = ~dcache_miss;
        if ($urandom_range(0, 7) == 0) icache_miss_addr = 16'($urandom);
        if ($urandom_range(0, 7) == 0) dcache_miss_addr = 16'($urandom);
      end
      if (m_idle(cyc) && $urandom_range(0, 3) == 0) inject_v = 1'b1;
      tick();
    end
    rst = 1'b0;
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    run_until_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
Shares the single multi-cycle main memory (memory4c, pipelined, fixed read latency) between I-cache and D-cache miss requests. It arbitrates between pending misses, sequences the 8-word block read burst, and steers per-word data/tag write enables to the granted cache. It sits in memory_system between both cache instances and main memory, and replaces the ad-hoc memory address/enable muxing.

Parameters:
AWIDTH, 16, byte address width
WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes)
MEM_LATENCY, 4, cycles from mem_rd_en/mem_addr to the matching mem_data_valid

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
icache_miss  in  1  I-cache miss_detected
icache_miss_addr  in  AWIDTH  I-cache miss address
dcache_miss  in  1  D-cache miss_detected
dcache_miss_addr  in  AWIDTH  D-cache miss address
mem_data_valid  in  1  main memory read data valid
mem_rd_en  out  1  read request to main memory, one word per cycle
mem_addr  out  AWIDTH  word address issued to main memory
fill_addr  out  AWIDTH  cache-side address of the word currently returning
icache_data_wen  out  1  I-cache data array write enable
icache_tag_wen  out  1  I-cache tag array write enable
dcache_data_wen  out  1  D-cache data array write enable
dcache_tag_wen  out  1  D-cache tag array write enable
busy  out  1  fill in progress; memory_system must block CPU SW writes to memory
grant_d  out  1  1 = current/last fill serves the D-cache, 0 = the I-cache

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, base=0, last_grant=I. All outputs are 0.
- States: IDLE, FILL, DONE.
- IDLE: if any miss is pending, latch the winner's address with bits[3:0] cleared into base, set grant_d, set last_grant, and go to FILL next cycle.
- Arbitration when both misses are pending: grant the side not granted last. After reset D wins first. With a single pending miss, it wins.
- There is no preemption. A granted fill always completes, even if its miss drops mid-fill.
- FILL issue side:
  - issue_cnt runs 0..WORDS_PER_BLOCK-1.
  - mem_rd_en=1 and mem_addr=base+2*issue_cnt for exactly WORDS_PER_BLOCK consecutive cycles, starting on the first FILL cycle.
  - After the last issue, mem_rd_en=0 and mem_addr holds its last value.
- FILL return side:
  - Each mem_data_valid increments rcv_cnt.
  - The granted cache's data_wen=1 in that same cycle, combinationally from mem_data_valid.
  - fill_addr=base+2*rcv_cnt.
  - On the final word (rcv_cnt==WORDS_PER_BLOCK-1 with valid), the granted cache's tag_wen=1 in the same cycle, then state goes to DONE.
- mem_data_valid is ignored outside FILL.
- The non-granted cache's enables stay 0 throughout.
- DONE: lasts one cycle so the cache's miss_detected can clear; all enables are 0. Then go to IDLE. A new miss can be granted in the IDLE cycle that follows.
- busy=1 in FILL and DONE.
- Timing, miss first seen at cycle t in IDLE:
  - Issues occur at t+1..t+8.
  - data_wen is high at t+1+L..t+8+L (L = MEM_LATENCY).
  - tag_wen is at t+8+L.
  - DONE is at t+9+L.
  - busy falls at t+10+L.
- Widths: counters are clog2(WORDS_PER_BLOCK) bits. Address adds wrap modulo 2^AWIDTH; base alignment guarantees no carry out of the block.
- A reset asserted mid-fill aborts the burst immediately. Memory responses still in flight must not produce write enables after reset releases, because the block is in IDLE and mem_data_valid is ignored there.

Decomposition:
- Shared package mem_pkg holds: state encoding (IDLE/FILL/DONE), BLOCK_OFFSET_BITS=4, WORD_BYTES=2, and the WORDS_PER_BLOCK/MEM_LATENCY defaults used by memory_system and the caches.
- One natural sub-module, fill_word_counter: a parameterised count-to-N counter with a terminal flag. It is instantiated twice, for issue_cnt and rcv_cnt.
- Arbitration and steering stay in the top module.

Test Plan:
- D-only miss: dcache_miss_addr=0x1236 at cycle 0.
  - mem_addr 0x1230..0x123E over cycles 1-8.
  - dcache_data_wen high cycles 5-12, with fill_addr 0x1230..0x123E.
  - dcache_tag_wen at cycle 12, busy low at cycle 14.
  - All icache enables stay 0.
- I-only miss: icache_miss_addr=0x00F0.
  - Same timing as the D-only case, with icache enables and grant_d=0.
  - Checks that an aligned address is unchanged.
- Simultaneous misses right after reset: D is served first (grant_d=1). I is granted in the IDLE cycle after D's DONE, its issues restarting at 0x(I base), and the two bursts never overlap.
- Alternation: hold both misses asserted across three fills. Grants go D, I, D, with no starvation.
- Reset mid-fill: assert rst at cycle 6 of a D fill.
  - All outputs 0 immediately.
  - Late mem_data_valid pulses after rst release produce no wen.
  - A subsequent I miss completes normally.
- Wrap/boundary: dcache_miss_addr=0xFFFE. Base is 0xFFF0, the last issued address is 0xFFFE, and no address wraps past 0xFFFF.
